regfile_bank: RTL and testbench

- 32-entry, WIDTH-bit, two-read/one-write register file for the 64-bit datapath.
- Consumes the write-back value produced by the result-select bus multiplexer (ALU result vs. memory data) and stores it.
- Feeds operand values to the ALU-input bus multiplexers.
- Register 31 is the architectural zero register.

---
 rtl/regfile_bank.sv | 77 +++++++
 tb/tb_regfile_bank.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_bank.sv
// ============================================================================
// Module   : regfile_bank
// Purpose  : 2R/1W register file with a hardwired zero entry and write bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_bank #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2
);

    localparam int              c_depth     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0] r_mem [0:c_depth-1];
    logic             w_wr_fire;
    logic             w_byp1;
    logic             w_byp2;

    // Qualified write; also the only condition under which bypass may fire.
    assign w_wr_fire = reset_n && wr_en && (wr_addr != c_zero_addr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_byp1 = w_wr_fire && (wr_addr == rd_addr1);
            assign w_byp2 = w_wr_fire && (wr_addr == rd_addr2);
        end else begin : g_no_bypass
            assign w_byp1 = 1'b0;
            assign w_byp2 = 1'b0;
        end
    endgenerate

    // The zero entry overrides both the stored value and the bypass path.
    always_comb begin
        rd_data1 = r_mem[rd_addr1];
        if (rd_addr1 == c_zero_addr) begin
            rd_data1 = '0;
        end else if (w_byp1) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = r_mem[rd_addr2];
        if (rd_addr2 == c_zero_addr) begin
            rd_data2 = '0;
        end else if (w_byp2) begin
            rd_data2 = wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_bank.sv
// ============================================================================
// Module   : tb_regfile_bank
// Purpose  : Scoreboard bench for regfile_bank, bypassing and non-bypassing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;
    logic [63:0] nb_data1;
    logic [63:0] nb_data2;

    typedef struct {
        string       name;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] f1;
        logic [63:0] f2;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ref_mem [0:31];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    regfile_bank #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2)
    );

    regfile_bank #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_data1), .rd_data2(nb_data2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: inputs settle at posedge+1, outputs are sampled on the negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, " byp p1"}, rd_data1, e.e1);
            chk({e.name, " byp p2"}, rd_data2, e.e2);
            chk({e.name, " nob p1"}, nb_data1, e.f1);
            chk({e.name, " nob p2"}, nb_data2, e.f2);
        end
    end

    task automatic drive(input logic rn, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        reset_n  = rn;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = a1;
        rd_addr2 = a2;
    endtask

    task automatic model_update(input logic rn, input logic we, input logic [4:0] wa,
                                input logic [63:0] wd);
        if (!rn) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        end else if (we && wa != 5'd31) begin
            ref_mem[wa] = wd;
        end
    endtask

    task automatic step(input logic rn, input logic we, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [63:0] e1, input logic [63:0] e2,
                        input logic [63:0] f1, input logic [63:0] f2, input string nm);
        exp_t e;
        drive(rn, we, wa, wd, a1, a2);
        e.name = nm; e.e1 = e1; e.e2 = e2; e.f1 = f1; e.f2 = f2;
        sb.push_back(e);
        model_update(rn, we, wa, wd);
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp, input logic rn,
                                           input logic we, input logic [4:0] wa,
                                           input logic [63:0] wd);
        if (a == 5'd31) return '0;
        if (byp && rn && we && wa == a && wa != 5'd31) return wd;
        return ref_mem[a];
    endfunction

    localparam logic [63:0] c_dead = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] c_ones = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic        rn, we;
        logic [4:0]  wa, a1, a2;
        logic [63:0] wd;
        int          wait_cycles;

        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;

        // First rising edge is the reset cycle; then every index reads 0.
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, "post-reset read");
        end

        step(1, 1, 5, c_dead, 0, 6, 0, 0, 0, 0, "write x5 cycle");
        step(1, 0, 0, 0, 5, 6, c_dead, 0, c_dead, 0, "x5 readback");

        step(1, 1, 31, c_ones, 31, 31, 0, 0, 0, 0, "x31 write cycle");
        step(1, 0, 0, 0, 31, 31, 0, 0, 0, 0, "x31 after write");
        for (int i = 0; i < 31; i++) begin
            logic [63:0] v;
            v = (i == 5) ? c_dead : 64'd0;
            step(1, 0, 0, 0, 5'(i), 5'(i), v, v, v, v, "x0-x30 intact");
        end

        step(1, 1, 7, 64'h1111, 0, 0, 0, 0, 0, 0, "write x7 old");
        step(1, 1, 7, 64'h2222, 7, 7, 64'h2222, 64'h2222, 64'h1111, 64'h1111, "bypass same cycle");
        step(1, 0, 0, 0, 7, 7, 64'h2222, 64'h2222, 64'h2222, 64'h2222, "bypass after edge");

        step(1, 1, 3, 64'h55, 3, 0, 64'h55, 0, 0, 0, "write x3");
        step(0, 1, 3, 64'hAA, 3, 7, 64'h55, 64'h2222, 64'h55, 64'h2222, "reset suppresses bypass");
        step(1, 1, 4, 64'h44, 3, 4, 0, 64'h44, 0, 0, "reset beats write");
        step(1, 0, 0, 0, 4, 7, 64'h44, 0, 64'h44, 0, "first write after reset");

        for (int n = 0; n < 10000; n++) begin
            logic [63:0] e1, e2, f1, f2;
            rn = 1'b1;
            we = 1'($urandom);
            wa = 5'($urandom);
            if ($urandom_range(0, 7) == 0) wa = 5'd31;
            wd = {$urandom, $urandom};
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
            e1 = exp_rd(a1, 1, rn, we, wa, wd);
            e2 = exp_rd(a2, 1, rn, we, wa, wd);
            f1 = exp_rd(a1, 0, rn, we, wa, wd);
            f2 = exp_rd(a2, 0, rn, we, wa, wd);
            step(rn, we, wa, wd, a1, a2, e1, e2, f1, f2, "random");
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
